aes_uart_tx_sched: RTL and testbench

Two-source transmit scheduler that sits between 128-bit block producers (AES ciphertext path, debug/status path) and the byte-wide UART transmitter. It arbitrates round-robin between the sources and captures the granted 128-bit block. It then sequences a 17-byte frame over the UART's start/busy handshake: one header byte identifying the source, then 16 data bytes, LSB byte first. It also detects a UART that fails to acknowledge a byte and aborts the frame.

---
 rtl/aes_uart_pkg.sv | 16 +
 rtl/uart_rr_arb2.sv | 28 ++
 rtl/aes_uart_tx_sched.sv | 127 ++++++++++++
 tb/tb_aes_uart_tx_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_uart_pkg.sv
// Shared types and defaults for the AES/debug block to UART transmit scheduler.
package aes_uart_pkg;

   localparam int         BYTES_PER_BLOCK     = 16;
   localparam logic [7:0] HDR0_DEFAULT        = 8'hA5;
   localparam logic [7:0] HDR1_DEFAULT        = 8'h5A;
   localparam int         ACK_TIMEOUT_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_ACK  = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-request round-robin arbiter; the remembered winner only moves on an accept.
module uart_rr_arb2 (
   input  logic clk,
   input  logic reset_n,
   input  logic req0,
   input  logic req1,
   input  logic accept,
   output logic grant0,
   output logic grant1
);

   logic last_grant;

   // On contention the source that did not win last time is served.
   always_comb begin
      grant0 = req0 && (!req1 || last_grant);
      grant1 = req1 && (!req0 || !last_grant);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
      end else if (accept) begin
         last_grant <= grant1;
      end
   end

endmodule

// File: rtl/aes_uart_tx_sched.sv
// Captures a 128-bit block from one of two sources and sends it to the UART as a
// header byte plus 16 data bytes (LSB first), aborting if the UART never acknowledges.
import aes_uart_pkg::*;

// state        | meaning
// ST_IDLE      | no frame; arbitrate and accept a block
// ST_SEND      | present byte, pulse tx_start once the UART is free
// ST_WAIT_ACK  | start issued, waiting for tx_busy to rise (bounded)
// ST_WAIT_DONE | UART sending, wait for tx_busy to fall then advance
module aes_uart_tx_sched #(
   parameter int         NUM_BYTES   = BYTES_PER_BLOCK,
   parameter logic [7:0] HDR0        = HDR0_DEFAULT,
   parameter logic [7:0] HDR1        = HDR1_DEFAULT,
   parameter int         ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   s0_valid,
   input  logic [8*NUM_BYTES-1:0] s0_data,
   output logic                   s0_ready,
   input  logic                   s1_valid,
   input  logic [8*NUM_BYTES-1:0] s1_data,
   output logic                   s1_ready,
   output logic                   tx_start,
   output logic [7:0]             tx_byte,
   input  logic                   tx_busy,
   output logic                   frame_active,
   output logic                   frame_src,
   output logic                   err_timeout,
   input  logic                   err_clear
);

   localparam int DW = 8 * NUM_BYTES;
   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   tx_state_e      state;
   logic [DW-1:0]  shreg;
   logic [CW-1:0]  byte_cnt;
   logic           hdr_pending;
   logic [TW-1:0]  to_cnt;
   logic           grant0;
   logic           grant1;
   logic           accept;

   uart_rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req0    (s0_valid),
      .req1    (s1_valid),
      .accept  (accept),
      .grant0  (grant0),
      .grant1  (grant1)
   );

   assign accept   = (state == ST_IDLE) && (grant0 || grant1);
   assign s0_ready = (state == ST_IDLE) && grant0;
   assign s1_ready = (state == ST_IDLE) && grant1;
   assign tx_start = (state == ST_SEND) && !tx_busy;
   assign tx_byte  = (state != ST_SEND) ? 8'h00 :
                     hdr_pending        ? (frame_src ? HDR1 : HDR0) :
                                          shreg[7:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         shreg        <= '0;
         byte_cnt     <= '0;
         hdr_pending  <= 1'b0;
         to_cnt       <= '0;
         frame_active <= 1'b0;
         frame_src    <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         // A timeout set later in this block overrides the clear.
         if (err_clear) err_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  shreg        <= grant1 ? s1_data : s0_data;
                  frame_src    <= grant1;
                  byte_cnt     <= CW'(NUM_BYTES);
                  hdr_pending  <= 1'b1;
                  frame_active <= 1'b1;
                  state        <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!tx_busy) begin
                  to_cnt <= '0;
                  state  <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (tx_busy) begin
                  state <= ST_WAIT_DONE;
               end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                  err_timeout  <= 1'b1;
                  frame_active <= 1'b0;
                  state        <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  if (hdr_pending) begin
                     hdr_pending <= 1'b0;
                     state       <= ST_SEND;
                  end else begin
                     shreg    <= shreg >> 8;
                     byte_cnt <= byte_cnt - CW'(1);
                     if (byte_cnt == CW'(1)) begin
                        frame_active <= 1'b0;
                        state        <= ST_IDLE;
                     end else begin
                        state <= ST_SEND;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_uart_tx_sched.sv
// Scoreboard bench: stimulus queues expected UART bytes, a monitor pops them on tx_start.
module tb_aes_uart_tx_sched;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         s0_valid = 1'b0, s1_valid = 1'b0;
   logic [127:0] s0_data = '0, s1_data = '0;
   logic         s0_ready, s1_ready;
   logic         tx_start;
   logic [7:0]   tx_byte;
   logic         tx_busy;
   logic         frame_active, frame_src, err_timeout;
   logic         err_clear = 1'b0;

   aes_uart_tx_sched dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s0_valid     (s0_valid),
      .s0_data      (s0_data),
      .s0_ready     (s0_ready),
      .s1_valid     (s1_valid),
      .s1_data      (s1_data),
      .s1_ready     (s1_ready),
      .tx_start     (tx_start),
      .tx_byte      (tx_byte),
      .tx_busy      (tx_busy),
      .frame_active (frame_active),
      .frame_src    (frame_src),
      .err_timeout  (err_timeout),
      .err_clear    (err_clear)
   );

   initial forever #5 clk = ~clk;

   // UART model: busy for busy_len cycles starting the cycle after a start.
   int   busy_len = 10;
   logic mute = 1'b0, force_busy = 1'b0;
   logic busy_q;
   int   bcnt;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= 1'b0;
         bcnt   <= 0;
      end else if (tx_start && !mute) begin
         busy_q <= 1'b1;
         bcnt   <= busy_len - 1;
      end else if (bcnt > 0) begin
         bcnt <= bcnt - 1;
      end else begin
         busy_q <= 1'b0;
      end
   end
   assign tx_busy = busy_q || force_busy;

   int         checks = 0, errors = 0;
   logic [7:0] exp_q[$];
   int         starts_q[$];
   int         grant_q[$];
   int         cyc = 0;
   int         fa_fall_cyc = -1, err_rise_cyc = -1;
   logic       fa_prev = 1'b0, err_prev = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every start must carry the next queued byte, never back-to-back.
   initial forever begin
      logic [7:0] e;
      @(negedge clk);
      if (tx_start) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_start actual=%0h expected=none", tx_byte);
         end else begin
            e = exp_q.pop_front();
            if (tx_byte !== e) begin
               errors++;
               $display("FAIL tx_byte actual=%0h expected=%0h", tx_byte, e);
            end
         end
         if (starts_q.size() > 0) check("start_one_cycle", int'(starts_q[$] == cyc - 1), 0);
         starts_q.push_back(cyc);
      end
      if (fa_prev && !frame_active) fa_fall_cyc = cyc;
      if (!err_prev && err_timeout) err_rise_cyc = cyc;
      fa_prev  = frame_active;
      err_prev = err_timeout;
   end

   function automatic void push_frame(input logic [7:0] hdr, input logic [127:0] d, input int n);
      exp_q.push_back(hdr);
      for (int i = 0; i < n - 1; i++) exp_q.push_back(d[8*i +: 8]);
   endfunction

   function automatic int outs_zero();
      return int'({s0_ready, s1_ready, tx_start, tx_byte, frame_active, frame_src, err_timeout} == 14'd0);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      s0_valid = 1'b0; s1_valid = 1'b0; err_clear = 1'b0;
      force_busy = 1'b0; mute = 1'b0;
      reset_n = 1'b0;
      #1 check("reset_outputs", outs_zero(), 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      starts_q.delete();
   endtask

   task automatic send_block(input int src, input logic [127:0] d);
      bit done = 0;
      @(negedge clk);
      if (src == 0) begin s0_data = d; s0_valid = 1'b1; end
      else          begin s1_data = d; s1_valid = 1'b1; end
      for (int i = 0; i < 400 && !done; i++) begin
         #1;
         if ((src == 0) ? s0_ready : s1_ready) begin
            @(posedge clk);
            #1;
            s0_valid = 1'b0; s1_valid = 1'b0;
            check("accept_src", int'(frame_src), src);
            check("accept_active", int'(frame_active), 1);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (!frame_active) done = 1;
      end
      #1;
      if (!done) check("frame_end_timeout", 0, 1);
   endtask

   task automatic run_contention(input logic [127:0] d0a, input logic [127:0] d0b,
                                 input logic [127:0] d1a, input int n_total);
      int n0 = 0, n1 = 0;
      bit a0, a1;
      grant_q.delete();
      @(negedge clk);
      s0_data = d0a; s1_data = d1a; s0_valid = 1'b1; s1_valid = 1'b1;
      for (int i = 0; i < 2000 && (n0 + n1) < n_total; i++) begin
         #1;
         a0 = s0_valid && s0_ready;
         a1 = s1_valid && s1_ready;
         @(posedge clk);
         #1;
         if (a0) begin
            n0++; grant_q.push_back(0);
            if (n0 == 1 && n_total == 3) s0_data = d0b;
            else s0_valid = 1'b0;
         end
         if (a1) begin
            n1++; grant_q.push_back(1);
            s1_valid = 1'b0;
         end
         @(negedge clk);
      end
      s0_valid = 1'b0; s1_valid = 1'b0;
      check("grant_count", grant_q.size(), n_total);
      wait_idle(600);
   endtask

   task automatic check_intervals(input int exp);
      for (int i = 1; i < starts_q.size(); i++)
         check("start_interval", starts_q[i] - starts_q[i-1], exp);
   endtask

   localparam logic [127:0] D_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] D_S1  = 128'hFFEEDDCCBBAA99887766554433221100;
   localparam logic [127:0] D_S0B = 128'h123456789ABCDEF00011223344556677;
   localparam logic [127:0] D_R   = 128'hC3C2C1C0B3B2B1B0A3A2A1A093929190;

   initial begin
      int exp_order[3];
      int rel;
      bit seen;
      exp_order = '{0, 1, 0};

      #12 check("por_outputs", outs_zero(), 1);
      @(negedge clk);
      reset_n = 1'b1;

      // Single source-0 block, UART busy 10 cycles
      busy_len = 10;
      push_frame(8'hA5, D_SEQ, 17);
      send_block(0, D_SEQ);
      wait_idle(600);
      check("frame1_starts", starts_q.size(), 17);
      check_intervals(12);
      if (starts_q.size() > 0) check("frame_active_fall", fa_fall_cyc - starts_q[$], 12);

      // Three contended frames from reset
      do_reset();
      busy_len = 3;
      push_frame(8'hA5, D_SEQ, 17);
      push_frame(8'h5A, D_S1, 17);
      push_frame(8'hA5, D_S0B, 17);
      run_contention(D_SEQ, D_S0B, D_S1, 3);
      for (int i = 0; i < grant_q.size() && i < 3; i++) check("grant_order", grant_q[i], exp_order[i]);
      if (starts_q.size() >= 18) check("frame_gap", starts_q[17] - starts_q[16], 6);

      // UART never acknowledges
      do_reset();
      mute = 1'b1;
      exp_q.push_back(8'hA5);
      send_block(0, D_SEQ);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (err_timeout) seen = 1;
      end
      #1;
      check("timeout_seen", int'(seen), 1);
      check("timeout_starts", starts_q.size(), 1);
      if (starts_q.size() > 0) check("timeout_latency", err_rise_cyc - starts_q[0], 5);
      check("abort_frame_active", int'(frame_active), 0);
      @(negedge clk);
      err_clear = 1'b1;
      @(posedge clk);
      #1 err_clear = 1'b0;
      check("err_clear", int'(err_timeout), 0);

      exp_q.push_back(8'h5A);
      send_block(1, D_S1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (tx_start) seen = 1;
      end
      check("timeout2_start", int'(seen), 1);
      repeat (4) @(negedge clk);
      err_clear = 1'b1;
      @(posedge clk);
      #1 err_clear = 1'b0;
      check("set_over_clear", int'(err_timeout), 1);
      check("abort2_frame_active", int'(frame_active), 0);
      mute = 1'b0;

      // Busy held high on entry to SEND
      do_reset();
      busy_len = 2;
      force_busy = 1'b1;
      push_frame(8'hA5, D_S0B, 17);
      send_block(0, D_S0B);
      repeat (5) begin
         @(negedge clk);
         check("held_start", int'(tx_start), 0);
      end
      @(posedge clk);
      #1 force_busy = 1'b0;
      rel = cyc;
      wait_idle(300);
      check("forced_starts", starts_q.size(), 17);
      if (starts_q.size() > 0) check("release_start", starts_q[0], rel);
      check_intervals(4);

      // Reset mid-frame after byte 5, then resend with contention
      do_reset();
      busy_len = 2;
      push_frame(8'hA5, D_R, 5);
      send_block(0, D_R);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (starts_q.size() >= 5) seen = 1;
      end
      check("midframe_reached", int'(seen), 1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check("midreset_outputs", outs_zero(), 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      push_frame(8'hA5, D_R, 17);
      push_frame(8'h5A, D_S1, 17);
      run_contention(D_R, D_R, D_S1, 2);
      for (int i = 0; i < grant_q.size() && i < 2; i++) check("post_reset_grant", grant_q[i], exp_order[i]);

      repeat (5) @(negedge clk);
      check("scoreboard_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
